// File: rtl/mem_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_stage_if
// Purpose  : Single-port data-memory bus (req/ready handshake) between the
//            MEM stage (master) and the data memory (slave).
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            ready;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ready, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_stage
// Purpose  : RISC-V MEM stage. Issues data-memory accesses, aligns store
//            data and byte enables, extends load data and owns MEM/WB.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int XLEN = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            valid_in,
  input  wire logic [XLEN-1:0] alu_result_in,
  input  wire logic [XLEN-1:0] store_data_in,
  input  wire logic [XLEN-1:0] pc_plus_4_in,
  input  wire logic [4:0]      rd_addr_in,
  input  wire logic            reg_write_en_in,
  input  wire logic [1:0]      mem_to_reg_in,
  input  wire logic            mem_read_in,
  input  wire logic            mem_write_in,
  input  wire logic [2:0]      funct3_in,
  output logic                 stall_out,
  mem_stage_if.master          dmem,
  output logic                 valid_out,
  output logic [XLEN-1:0]      alu_result_out,
  output logic [XLEN-1:0]      load_data_out,
  output logic [XLEN-1:0]      pc_plus_4_out,
  output logic [4:0]           rd_addr_out,
  output logic                 reg_write_en_out,
  output logic [1:0]           mem_to_reg_out,
  output logic                 mem_exc_out
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t          r_state;
  state_t          w_next;

  logic            w_mem_op;
  logic            w_f3_legal;
  logic            w_misaligned;
  logic            w_fault;
  logic            w_good;
  logic [1:0]      w_off;
  logic [1:0]      w_size;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_ext;

  assign w_off  = alu_result_in[1:0];
  assign w_size = funct3_in[1:0];

  // Classify the incoming instruction: legal size/sign code, alignment, fault
  always_comb begin
    w_mem_op   = valid_in & (mem_read_in | mem_write_in);
    w_f3_legal = 1'b0;
    if (mem_read_in & mem_write_in) begin
      w_f3_legal = 1'b0;
    end else if (mem_write_in) begin
      w_f3_legal = (funct3_in == 3'b000) | (funct3_in == 3'b001) | (funct3_in == 3'b010);
    end else begin
      w_f3_legal = (funct3_in == 3'b000) | (funct3_in == 3'b001) | (funct3_in == 3'b010) |
                   (funct3_in == 3'b100) | (funct3_in == 3'b101);
    end
    w_misaligned = ((w_size == 2'b01) & w_off[0]) | ((w_size == 2'b10) & (w_off != 2'b00));
    w_fault      = w_mem_op & (~w_f3_legal | w_misaligned);
    w_good       = w_mem_op & ~w_fault;
  end

  // Store-lane replication and byte enables by access size
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_in;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
      end
    endcase
  end

  // Pick the addressed byte/halfword from the read word and extend it
  always_comb begin
    w_byte = dmem.rdata[7:0];
    case (w_off)
      2'b00:   w_byte = dmem.rdata[7:0];
      2'b01:   w_byte = dmem.rdata[15:8];
      2'b10:   w_byte = dmem.rdata[23:16];
      default: w_byte = dmem.rdata[31:24];
    endcase
    w_half     = w_off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    w_load_ext = dmem.rdata;
    case (funct3_in)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = dmem.rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and stall; nothing is stalled while reset is asserted
  always_comb begin
    w_next    = r_state;
    stall_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_good) begin
          w_next    = S_REQ;
          stall_out = ~rst;
        end
      end
      S_REQ: begin
        if (dmem.ready) w_next = S_IDLE;
        else            stall_out = ~rst;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bus request registers and the MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.req         <= 1'b0;
      dmem.we          <= 1'b0;
      dmem.addr        <= '0;
      dmem.wdata       <= '0;
      dmem.be          <= 4'b0000;
      valid_out        <= 1'b0;
      alu_result_out   <= '0;
      load_data_out    <= '0;
      pc_plus_4_out    <= '0;
      rd_addr_out      <= 5'd0;
      reg_write_en_out <= 1'b0;
      mem_to_reg_out   <= 2'b00;
      mem_exc_out      <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_good) begin
        // Launch the access; MEM/WB takes a bubble while it is outstanding
        dmem.req         <= 1'b1;
        dmem.we          <= mem_write_in;
        dmem.addr        <= {alu_result_in[XLEN-1:2], 2'b00};
        dmem.be          <= w_be;
        dmem.wdata       <= w_wdata;
        valid_out        <= 1'b0;
        alu_result_out   <= '0;
        load_data_out    <= '0;
        pc_plus_4_out    <= '0;
        rd_addr_out      <= 5'd0;
        reg_write_en_out <= 1'b0;
        mem_to_reg_out   <= 2'b00;
        mem_exc_out      <= 1'b0;
      end else begin
        // Non-memory op, faulting op or bubble passes straight through
        valid_out        <= valid_in;
        alu_result_out   <= valid_in ? alu_result_in : '0;
        load_data_out    <= '0;
        pc_plus_4_out    <= valid_in ? pc_plus_4_in : '0;
        rd_addr_out      <= valid_in ? rd_addr_in : 5'd0;
        reg_write_en_out <= valid_in & reg_write_en_in & ~w_fault;
        mem_to_reg_out   <= valid_in ? mem_to_reg_in : 2'b00;
        mem_exc_out      <= w_fault;
      end
    end else if (dmem.ready) begin
      // Access completes: retire the held instruction into MEM/WB
      dmem.req         <= 1'b0;
      dmem.we          <= 1'b0;
      valid_out        <= 1'b1;
      alu_result_out   <= alu_result_in;
      load_data_out    <= mem_read_in ? w_load_ext : '0;
      pc_plus_4_out    <= pc_plus_4_in;
      rd_addr_out      <= rd_addr_in;
      reg_write_en_out <= reg_write_en_in;
      mem_to_reg_out   <= mem_to_reg_in;
      mem_exc_out      <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [31:0] pc_plus_4_in;
  logic [4:0]  rd_addr_in;
  logic        reg_write_en_in;
  logic [1:0]  mem_to_reg_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] alu_result_out;
  logic [31:0] load_data_out;
  logic [31:0] pc_plus_4_out;
  logic [4:0]  rd_addr_out;
  logic        reg_write_en_out;
  logic [1:0]  mem_to_reg_out;
  logic        mem_exc_out;

  int n_checks = 0;
  int n_errors = 0;
  int st;

  // bus snapshot taken in the cycle the access completes
  logic        s_req, s_we, s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  mem_stage_if #(.XLEN(32)) dmem ();

  mem_stage #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .alu_result_in    (alu_result_in),
    .store_data_in    (store_data_in),
    .pc_plus_4_in     (pc_plus_4_in),
    .rd_addr_in       (rd_addr_in),
    .reg_write_en_in  (reg_write_en_in),
    .mem_to_reg_in    (mem_to_reg_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .funct3_in        (funct3_in),
    .stall_out        (stall_out),
    .dmem             (dmem),
    .valid_out        (valid_out),
    .alu_result_out   (alu_result_out),
    .load_data_out    (load_data_out),
    .pc_plus_4_out    (pc_plus_4_out),
    .rd_addr_out      (rd_addr_out),
    .reg_write_en_out (reg_write_en_out),
    .mem_to_reg_out   (mem_to_reg_out),
    .mem_exc_out      (mem_exc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    valid_in = 0; alu_result_in = 0; store_data_in = 0; pc_plus_4_in = 0;
    rd_addr_in = 0; reg_write_en_in = 0; mem_to_reg_in = 0;
    mem_read_in = 0; mem_write_in = 0; funct3_in = 0;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic rwe, input logic [1:0] m2r,
                        input logic rd_en, input logic wr_en, input logic [2:0] f3);
    valid_in = 1; alu_result_in = alu; store_data_in = sd; pc_plus_4_in = pc4;
    rd_addr_in = rd; reg_write_en_in = rwe; mem_to_reg_in = m2r;
    mem_read_in = rd_en; mem_write_in = wr_en; funct3_in = f3;
  endtask

  // Run one memory access whose inputs are already applied; memory answers
  // after 'lat' wait cycles in REQ. Returns the number of stalled cycles.
  task automatic mem_access(input int lat, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    @(negedge clk); if (stall_out) stalls++;
    @(posedge clk); #1;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); if (stall_out) stalls++;
      @(posedge clk); #1;
    end
    dmem.ready = 1'b1;
    dmem.rdata = rdata;
    @(negedge clk);
    if (stall_out) stalls++;
    s_req = dmem.req; s_we = dmem.we; s_addr = dmem.addr;
    s_wdata = dmem.wdata; s_be = dmem.be; s_valid = valid_out;
    @(posedge clk); #1;
    dmem.ready = 1'b0;
    dmem.rdata = 32'h0;
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    dmem.ready = 1'b0;
    dmem.rdata = 32'h0;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_req", {31'd0, dmem.req}, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_load", load_data_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LW at 0x100, ready three cycles after req
    set_op(32'h100, 32'h0, 32'h104, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
    mem_access(3, 32'hDEADBEEF, st);
    check("lw_stalls", st, 32'd4);
    check("lw_req", {31'd0, s_req}, 32'd1);
    check("lw_we", {31'd0, s_we}, 32'd0);
    check("lw_addr", s_addr, 32'h100);
    check("lw_be", {28'd0, s_be}, 32'hF);
    check("lw_bubble", {31'd0, s_valid}, 32'd0);
    @(negedge clk);
    check("lw_valid", {31'd0, valid_out}, 32'd1);
    check("lw_data", load_data_out, 32'hDEADBEEF);
    check("lw_m2r", {30'd0, mem_to_reg_out}, 32'd1);
    check("lw_rd", {27'd0, rd_addr_out}, 32'd5);
    check("lw_req_clr", {31'd0, dmem.req}, 32'd0);
    check("lw_stall_clr", {31'd0, stall_out}, 32'd0);

    // LB / LBU at 0x103, rdata 0x80FF0000
    @(posedge clk); #1;
    set_op(32'h103, 32'h0, 32'h0, 5'd6, 1'b1, 2'b01, 1'b1, 1'b0, 3'b000);
    mem_access(0, 32'h80FF0000, st);
    check("lb_stalls", st, 32'd1);
    check("lb_addr", s_addr, 32'h100);
    check("lb_be", {28'd0, s_be}, 32'h8);
    @(negedge clk);
    check("lb_data", load_data_out, 32'hFFFFFF80);
    @(posedge clk); #1;
    set_op(32'h103, 32'h0, 32'h0, 5'd6, 1'b1, 2'b01, 1'b1, 1'b0, 3'b100);
    mem_access(0, 32'h80FF0000, st);
    @(negedge clk);
    check("lbu_data", load_data_out, 32'h00000080);

    // LH at 0x102 and LHU at 0x100, rdata 0x80011234
    @(posedge clk); #1;
    set_op(32'h102, 32'h0, 32'h0, 5'd7, 1'b1, 2'b01, 1'b1, 1'b0, 3'b001);
    mem_access(1, 32'h80011234, st);
    check("lh_be", {28'd0, s_be}, 32'hC);
    @(negedge clk);
    check("lh_data", load_data_out, 32'hFFFF8001);
    @(posedge clk); #1;
    set_op(32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 2'b01, 1'b1, 1'b0, 3'b101);
    mem_access(0, 32'h80011234, st);
    check("lhu_be", {28'd0, s_be}, 32'h3);
    @(negedge clk);
    check("lhu_data", load_data_out, 32'h00001234);

    // SB rs2=0x12345678 at 0x102
    @(posedge clk); #1;
    set_op(32'h102, 32'h12345678, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000);
    mem_access(1, 32'h0, st);
    check("sb_we", {31'd0, s_we}, 32'd1);
    check("sb_be", {28'd0, s_be}, 32'h4);
    check("sb_wdata", s_wdata, 32'h78787878);
    @(negedge clk);
    check("sb_valid", {31'd0, valid_out}, 32'd1);
    check("sb_rwe", {31'd0, reg_write_en_out}, 32'd0);

    // SH rs2=0x12345678 at 0x102
    @(posedge clk); #1;
    set_op(32'h102, 32'h12345678, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b001);
    mem_access(0, 32'h0, st);
    check("sh_be", {28'd0, s_be}, 32'hC);
    check("sh_wdata", s_wdata, 32'h56785678);

    // Misaligned LH at 0x101: no request, no stall, exception next cycle
    @(posedge clk); #1;
    set_op(32'h101, 32'h0, 32'h0, 5'd8, 1'b1, 2'b01, 1'b1, 1'b0, 3'b001);
    @(negedge clk);
    check("mis_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check("mis_req", {31'd0, dmem.req}, 32'd0);
    check("mis_valid", {31'd0, valid_out}, 32'd1);
    check("mis_exc", {31'd0, mem_exc_out}, 32'd1);
    check("mis_rwe", {31'd0, reg_write_en_out}, 32'd0);

    // Illegal funct3 (011) on an aligned load
    @(posedge clk); #1;
    set_op(32'h100, 32'h0, 32'h0, 5'd8, 1'b1, 2'b01, 1'b1, 1'b0, 3'b011);
    @(negedge clk);
    check("ill_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check("ill_exc", {31'd0, mem_exc_out}, 32'd1);
    check("ill_req", {31'd0, dmem.req}, 32'd0);

    // Back-to-back ADD then JAL
    @(posedge clk); #1;
    set_op(32'h5, 32'h0, 32'h88, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    check("add_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    set_op(32'h999, 32'h0, 32'h204, 5'd1, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    check("add_alu", alu_result_out, 32'h5);
    check("add_m2r", {30'd0, mem_to_reg_out}, 32'd0);
    check("add_exc", {31'd0, mem_exc_out}, 32'd0);
    check("add_req", {31'd0, dmem.req}, 32'd0);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check("jal_pc4", pc_plus_4_out, 32'h204);
    check("jal_m2r", {30'd0, mem_to_reg_out}, 32'd2);
    check("jal_req", {31'd0, dmem.req}, 32'd0);
    @(negedge clk);
    check("bubble_valid", {31'd0, valid_out}, 32'd0);

    // Reset pulsed while a load is waiting in REQ
    @(posedge clk); #1;
    set_op(32'h100, 32'h0, 32'h104, 5'd3, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", {31'd0, dmem.req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_req", {31'd0, dmem.req}, 32'd0);
    check("arst_stall", {31'd0, stall_out}, 32'd0);
    check("arst_valid", {31'd0, valid_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_access(1, 32'h0BADF00D, st);
    check("post_rst_stalls", st, 32'd2);
    @(negedge clk);
    check("post_rst_valid", {31'd0, valid_out}, 32'd1);
    check("post_rst_data", load_data_out, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
